// File: rtl/eth_tx_mii_framer.sv
// AXI4-Stream byte stream to 4-bit MII transmitter: preamble/SFD, low-nibble-first data, IFG,
// underrun/oversize abort with tx_er. Optional statistics counters under `ETH_TX_STATS_EN`.
module eth_tx_mii_framer #(
    parameter int DATA_WIDTH      = 8,
    parameter int PREAMBLE_BYTES  = 7,
    parameter int IFG_BYTES       = 12,
    parameter int MAX_FRAME_BYTES = 1518
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [3:0]            mii_txd,
    output logic                  mii_tx_en,
    output logic                  mii_tx_er,
    output logic                  busy,
    output logic                  underrun,
    output logic                  oversize
`ifdef ETH_TX_STATS_EN
    ,
    output logic [31:0]           stat_frames,
    output logic [31:0]           stat_bytes,
    output logic [15:0]           stat_errors
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_PREAMBLE, S_DATA, S_ERROR, S_DRAIN, S_IFG
    } state_t;

    // r_cnt value on the SFD (0xD) cycle, and the value just before it.
    localparam logic [15:0] PRE_SFD     = 16'(2 * PREAMBLE_BYTES + 1);
    localparam logic [15:0] PRE_PRE_SFD = 16'(2 * PREAMBLE_BYTES);
    localparam logic [15:0] IFG_LAST    = 16'(2 * IFG_BYTES - 1);
    localparam logic [15:0] MAX_BYTES   = 16'(MAX_FRAME_BYTES);

    state_t      r_state;
    logic [15:0] r_cnt;
    logic [15:0] r_bytes;
    logic [3:0]  r_hi;
    logic        r_last;
    logic        r_err_last;
    logic [3:0]  r_txd;
    logic        r_tx_en;
    logic        r_tx_er;

    logic        w_sfd;
    logic        w_hi;
    logic        w_req;
    logic [15:0] w_bytes_inc;

    // A byte transfers on a rising edge where s_axis_tvalid && s_axis_tready; tready is a function of state only.
    assign w_sfd         = (r_state == S_PREAMBLE) && (r_cnt == PRE_SFD);
    assign w_hi          = (r_state == S_DATA) && r_cnt[0];
    assign w_req         = w_sfd || (w_hi && !r_last);
    assign s_axis_tready = w_req || (r_state == S_DRAIN);
    assign underrun      = w_req && !s_axis_tvalid;
    assign oversize      = w_req && s_axis_tvalid && (r_bytes >= MAX_BYTES);
    assign w_bytes_inc   = (r_bytes == 16'hFFFF) ? r_bytes : r_bytes + 16'd1;

    assign mii_txd   = r_txd;
    assign mii_tx_en = r_tx_en;
    assign mii_tx_er = r_tx_er;
    assign busy      = (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 16'd0;
            r_bytes    <= 16'd0;
            r_hi       <= 4'd0;
            r_last     <= 1'b0;
            r_err_last <= 1'b0;
            r_txd      <= 4'd0;
            r_tx_en    <= 1'b0;
            r_tx_er    <= 1'b0;
        end else if (w_req) begin
            // Byte request on the SFD cycle or a high-nibble cycle: accept, abort on underrun or oversize.
            r_cnt <= 16'd0;
            if (!s_axis_tvalid) begin
                r_state    <= S_ERROR;
                r_err_last <= 1'b0;
                r_txd      <= 4'd0;
                r_tx_en    <= 1'b1;
                r_tx_er    <= 1'b1;
            end else begin
                r_bytes <= w_bytes_inc;
                if (r_bytes >= MAX_BYTES) begin
                    r_state    <= S_ERROR;
                    r_err_last <= s_axis_tlast;
                    r_txd      <= 4'd0;
                    r_tx_en    <= 1'b1;
                    r_tx_er    <= 1'b1;
                end else begin
                    r_state <= S_DATA;
                    r_hi    <= s_axis_tdata[7:4];
                    r_last  <= s_axis_tlast;
                    r_txd   <= s_axis_tdata[3:0];
                    r_tx_en <= 1'b1;
                    r_tx_er <= 1'b0;
                end
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_txd   <= 4'd0;
                    r_tx_en <= 1'b0;
                    r_tx_er <= 1'b0;
                    if (s_axis_tvalid) begin
                        r_state <= S_PREAMBLE;
                        r_cnt   <= 16'd0;
                        r_bytes <= 16'd0;
                        r_txd   <= 4'h5;
                        r_tx_en <= 1'b1;
                    end
                end
                S_PREAMBLE: begin
                    r_cnt <= r_cnt + 16'd1;
                    r_txd <= (r_cnt == PRE_PRE_SFD) ? 4'hD : 4'h5;
                end
                S_DATA: begin
                    if (!r_cnt[0]) begin
                        r_cnt <= 16'd1;
                        r_txd <= r_hi;
                    end else begin
                        // High nibble of the tlast byte has just gone out.
                        r_state <= S_IFG;
                        r_cnt   <= 16'd0;
                        r_txd   <= 4'd0;
                        r_tx_en <= 1'b0;
                    end
                end
                S_ERROR: begin
                    if (r_cnt == 16'd1) begin
                        r_state <= r_err_last ? S_IFG : S_DRAIN;
                        r_cnt   <= 16'd0;
                        r_txd   <= 4'd0;
                        r_tx_en <= 1'b0;
                        r_tx_er <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_DRAIN: begin
                    if (s_axis_tvalid && s_axis_tlast) begin
                        r_state <= S_IFG;
                        r_cnt   <= 16'd0;
                    end
                end
                S_IFG: begin
                    if (r_cnt == IFG_LAST) begin
                        r_state <= S_IDLE;
                        r_cnt   <= 16'd0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef ETH_TX_STATS_EN
    logic [31:0] r_stat_frames;
    logic [31:0] r_stat_bytes;
    logic [15:0] r_stat_errors;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_frames <= 32'd0;
            r_stat_bytes  <= 32'd0;
            r_stat_errors <= 32'd0;
        end else begin
            if (w_hi && r_last) begin
                r_stat_frames <= r_stat_frames + 32'd1;
                r_stat_bytes  <= r_stat_bytes + {16'd0, r_bytes};
            end
            if (underrun || oversize) begin
                r_stat_errors <= r_stat_errors + 16'd1;
            end
        end
    end

    assign stat_frames = r_stat_frames;
    assign stat_bytes  = r_stat_bytes;
    assign stat_errors = r_stat_errors;
`endif

endmodule

// File: tb/tb_eth_tx_mii_framer.sv
// Scoreboard bench for eth_tx_mii_framer: expected nibbles, tx_en run lengths and post-frame
// busy lengths are queued at stimulus time and checked by an independent negedge monitor.
module tb_eth_tx_mii_framer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] s_axis_tdata;
    logic       s_axis_tvalid;
    logic       s_axis_tready;
    logic       s_axis_tlast;
    logic [3:0] mii_txd;
    logic       mii_tx_en;
    logic       mii_tx_er;
    logic       busy;
    logic       underrun;
    logic       oversize;
`ifdef ETH_TX_STATS_EN
    logic [31:0] stat_frames;
    logic [31:0] stat_bytes;
    logic [15:0] stat_errors;
`endif

    always #5 clk = ~clk;

    eth_tx_mii_framer dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .mii_txd       (mii_txd),
        .mii_tx_en     (mii_tx_en),
        .mii_tx_er     (mii_tx_er),
        .busy          (busy),
        .underrun      (underrun),
        .oversize      (oversize)
`ifdef ETH_TX_STATS_EN
        ,
        .stat_frames   (stat_frames),
        .stat_bytes    (stat_bytes),
        .stat_errors   (stat_errors)
`endif
    );

    int checks   = 0;
    int failures = 0;

    logic [4:0] exp_q[$];      // {tx_er, txd} per tx_en cycle
    int         en_run_q[$];   // expected tx_en high-run length per burst
    int         post_q[$];     // expected busy cycles with tx_en low after each burst

    int         cyc        = 0;
    int         fall_cyc   = 0;
    int         last_gap   = 0;
    int         en_run     = 0;
    int         post_run   = 0;
    int         u_cnt      = 0;
    int         o_cnt      = 0;
    int         tready_cnt = 0;
    logic [3:0] first_tready_txd = 4'd0;
    logic       prev_en    = 1'b0;
    logic       in_post    = 1'b0;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    function automatic void fail_empty(input string name);
        checks++;
        failures++;
        $display("FAIL %s: DUT output with no expected entry queued", name);
    endfunction

    // Monitor / scoreboard
    always @(negedge clk) begin
        logic [4:0] e;
        cyc++;
        if (s_axis_tready) begin
            if (tready_cnt == 0) first_tready_txd = mii_txd;
            tready_cnt++;
        end
        if (underrun) u_cnt++;
        if (oversize) o_cnt++;
        if (mii_tx_en) begin
            if (!prev_en) begin
                last_gap = cyc - fall_cyc;
                en_run   = 0;
            end
            en_run++;
            if (exp_q.size() == 0) begin
                fail_empty("nibble");
            end else begin
                e = exp_q.pop_front();
                chk("nibble", int'({mii_tx_er, mii_txd}), int'(e));
            end
        end else begin
            chk("idle_txd_er", int'({mii_tx_er, mii_txd}), 0);
            if (prev_en) begin
                fall_cyc = cyc;
                if (en_run_q.size() == 0) fail_empty("en_run");
                else chk("en_run", en_run, en_run_q.pop_front());
                in_post  = 1'b1;
                post_run = 0;
            end
            if (in_post) begin
                if (busy) begin
                    post_run++;
                end else begin
                    if (post_q.size() == 0) fail_empty("post_busy");
                    else chk("post_busy", post_run, post_q.pop_front());
                    in_post = 1'b0;
                end
            end
        end
        prev_en = mii_tx_en;
    end

    // Expected wire image of a frame: preamble+SFD, n_tx bytes, optional 2-cycle error tail.
    task automatic push_frame(input int n_tx, input bit err);
        logic [7:0] b;
        for (int i = 0; i < 15; i++) exp_q.push_back({1'b0, 4'h5});
        exp_q.push_back({1'b0, 4'hD});
        for (int i = 0; i < n_tx; i++) begin
            b = 8'(i);
            exp_q.push_back({1'b0, b[3:0]});
            exp_q.push_back({1'b0, b[7:4]});
        end
        if (err) begin
            exp_q.push_back(5'b1_0000);
            exp_q.push_back(5'b1_0000);
        end
    endtask

    // Driver: byte i carries data i[7:0]; drop_idx >= 0 withholds tvalid for 2 cycles before that byte.
    task automatic send_frame(input int n, input int drop_idx);
        int   idx   = 0;
        int   guard = 0;
        bit   acc;
        bit   dropped = 1'b0;
        while (idx < n) begin
            if (idx == drop_idx && !dropped) begin
                s_axis_tvalid = 1'b0;
                repeat (2) @(posedge clk);
                #1;
                dropped = 1'b1;
            end
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = 8'(idx);
            s_axis_tlast  = (idx == n - 1);
            @(negedge clk);
            acc = s_axis_tready;
            @(posedge clk);
            #1;
            if (acc) idx++;
            guard++;
            if (guard > 4 * n + 200) begin
                chk("driver_timeout", idx, n);
                break;
            end
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 4000);
        if (busy) chk(name, 1, 0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int u0;
        int o0;
        rst           = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = 8'd0;
        s_axis_tlast  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tx_en", mii_tx_en, 0);
        chk("rst_txd", mii_txd, 0);
        chk("rst_tx_er", mii_tx_er, 0);
        chk("rst_tready", s_axis_tready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_oversize", oversize, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single 64-byte frame
        push_frame(64, 1'b0);
        en_run_q.push_back(144);
        post_q.push_back(24);
        tready_cnt = 0;
        send_frame(64, -1);
        wait_idle("t1_idle_timeout");
        chk("t1_tready_count", tready_cnt, 64);
        chk("t1_first_tready_txd", int'(first_tready_txd), 13);

        // Two back-to-back 60-byte frames
        for (int f = 0; f < 2; f++) begin
            push_frame(60, 1'b0);
            en_run_q.push_back(136);
            post_q.push_back(24);
        end
        send_frame(60, -1);
        send_frame(60, -1);
        wait_idle("b2b_idle_timeout");
        chk("b2b_gap", last_gap, 25);

        // Underrun on the 11th byte request: 10 bytes on the wire, 50 drained
        u0 = u_cnt;
        o0 = o_cnt;
        push_frame(10, 1'b1);
        en_run_q.push_back(16 + 20 + 2);
        post_q.push_back(50 + 24);
        send_frame(60, 10);
        wait_idle("underrun_idle_timeout");
        chk("underrun_pulses", u_cnt - u0, 1);
        chk("underrun_no_oversize", o_cnt - o0, 0);

        // Oversize: 1519-byte frame, 1518 transmitted, no drain
        u0 = u_cnt;
        o0 = o_cnt;
        push_frame(1518, 1'b1);
        en_run_q.push_back(16 + 3036 + 2);
        post_q.push_back(24);
        send_frame(1519, -1);
        wait_idle("oversize_idle_timeout");
        chk("oversize_pulses", o_cnt - o0, 1);
        chk("oversize_no_underrun", u_cnt - u0, 0);

`ifdef ETH_TX_STATS_EN
        chk("stat_frames", int'(stat_frames), 3);
        chk("stat_bytes", int'(stat_bytes), 184);
        chk("stat_errors", int'(stat_errors), 2);
`endif

        // Reset during preamble nibble 5
        for (int i = 0; i < 5; i++) exp_q.push_back({1'b0, 4'h5});
        en_run_q.push_back(5);
        post_q.push_back(0);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 8'd0;
        s_axis_tlast  = 1'b0;
        @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        rst           = 1'b1;
        s_axis_tvalid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_tx_en", mii_tx_en, 0);
        chk("midrst_tready", s_axis_tready, 0);
        chk("midrst_busy", busy, 0);
        @(posedge clk);
        #1;

        // Fresh frame after reset
        push_frame(60, 1'b0);
        en_run_q.push_back(136);
        post_q.push_back(24);
        send_frame(60, -1);
        wait_idle("post_rst_idle_timeout");

        chk("exp_q_empty", exp_q.size(), 0);
        chk("en_run_q_empty", en_run_q.size(), 0);
        chk("post_q_empty", post_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
